// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard front end: synchronises and deframes PS/2 traffic and turns arrow-key make/break codes into a one-hot held direction.
// Optional macro PS2_WASD_EN adds W/A/S/D (non-extended codes) to the direction map.
module ps2_direction_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [3:0] dir_out,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             clk_meta_q, clk_sync_q, clk_prev_q;
   logic             dat_meta_q, dat_sync_q;
   state_t           state_q;
   logic [2:0]       bit_cnt_q;
   logic [CNT_W-1:0] tmo_cnt_q;
   logic [7:0]       shift_q;
   logic             par_q;
   logic             ext_q, brk_q;
   logic [3:0]       dir_q, dir_d, key_dir;
   logic [7:0]       scan_code_q;
   logic             scan_valid_q, frame_err_q;
   logic             fall_edge, parity_ok, timeout;

   // Idle level of the PS/2 lines is high, so the synchronisers reset to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
         clk_meta_q <= ps2_clk;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat;
         dat_sync_q <= dat_meta_q;
      end
   end

   assign fall_edge = clk_prev_q & ~clk_sync_q;
   assign parity_ok = ^{shift_q, par_q};
   assign timeout   = (state_q != IDLE) && !fall_edge && (tmo_cnt_q == TIMEOUT_LAST);

   always_comb begin
      // NOTE: defaults first so every path assigns key_dir/dir_d and no latch is inferred.
      key_dir = 4'b0000;
      dir_d   = dir_q;
      if (ext_q) begin
         case (shift_q)
            8'h75:   key_dir = 4'b0001;
            8'h72:   key_dir = 4'b0010;
            8'h6B:   key_dir = 4'b0100;
            8'h74:   key_dir = 4'b1000;
            default: key_dir = 4'b0000;
         endcase
      end
`ifdef PS2_WASD_EN
      else begin
         case (shift_q)
            8'h1D:   key_dir = 4'b0001;
            8'h1B:   key_dir = 4'b0010;
            8'h1C:   key_dir = 4'b0100;
            8'h23:   key_dir = 4'b1000;
            default: key_dir = 4'b0000;
         endcase
      end
`endif
      // Newest press wins; a break only releases the key currently held.
      if (key_dir != 4'b0000) begin
         if (!brk_q)                dir_d = key_dir;
         else if (dir_q == key_dir) dir_d = 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         dir_q        <= '0;
         scan_code_q  <= '0;
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (state_q == IDLE || fall_edge) tmo_cnt_q <= '0;
         else                              tmo_cnt_q <= tmo_cnt_q + 1'b1;

         if (timeout) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
         end else if (fall_edge) begin
            case (state_q)
               IDLE: begin
                  if (!dat_sync_q) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end
               end
               DATA: begin
                  shift_q   <= {dat_sync_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_q   <= dat_sync_q;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (parity_ok && dat_sync_q) begin
                     scan_code_q  <= shift_q;
                     scan_valid_q <= 1'b1;
                     if (shift_q == 8'hE0)      ext_q <= 1'b1;
                     else if (shift_q == 8'hF0) brk_q <= 1'b1;
                     else begin
                        dir_q <= dir_d;
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     ext_q       <= 1'b0;
                     brk_q       <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign dir_out    = dir_q;
   assign scan_code  = scan_code_q;
   assign scan_valid = scan_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Self-checking bench for ps2_direction_decoder: scoreboard of expected scan/error events plus direct direction checks.
// Honours PS2_WASD_EN the same way as the design.
module tb_ps2_direction_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [3:0] dir_out;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit         is_scan;
      logic [7:0] code;
      logic [3:0] dir;
   } exp_t;

   exp_t sb_q[$];

   // Reference state of the key decoder.
   logic       m_ext, m_brk;
   logic [3:0] m_dir;

   ps2_direction_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_dat    (ps2_dat),
      .dir_out    (dir_out),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .frame_err  (frame_err)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] key_map(input logic ext, input logic [7:0] code);
      logic [8:0] k;
      k = {ext, code};
      case (k)
         9'h175:  return 4'b0001;
         9'h172:  return 4'b0010;
         9'h16B:  return 4'b0100;
         9'h174:  return 4'b1000;
`ifdef PS2_WASD_EN
         9'h01D:  return 4'b0001;
         9'h01B:  return 4'b0010;
         9'h01C:  return 4'b0100;
         9'h023:  return 4'b1000;
`endif
         default: return 4'b0000;
      endcase
   endfunction

   task automatic expect_frame(input logic [7:0] data, input bit good);
      exp_t       e;
      logic [3:0] kd;
      if (!good) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
         e = '{is_scan: 1'b0, code: 8'h00, dir: m_dir};
      end else begin
         if (data == 8'hE0) m_ext = 1'b1;
         else if (data == 8'hF0) m_brk = 1'b1;
         else begin
            kd = key_map(m_ext, data);
            if (kd != 4'b0000) begin
               if (!m_brk) m_dir = kd;
               else if (m_dir == kd) m_dir = 4'b0000;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
         e = '{is_scan: 1'b1, code: data, dir: m_dir};
      end
      sb_q.push_back(e);
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_dat = b;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic ps2_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop);
      expect_frame(data, !(bad_par || bad_stop));
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(data[i]);
      ps2_bit(~^data ^ bad_par);
      ps2_bit(!bad_stop);
      ps2_dat = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] data);
      ps2_frame(data, 1'b0, 1'b0);
   endtask

   // Scoreboard consumer: every output pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && (scan_valid || frame_err)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, scan_valid, frame_err}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("pulse_kind", {30'd0, scan_valid, frame_err}, {30'd0, e.is_scan, !e.is_scan});
            if (e.is_scan) check("scan_code", scan_code, e.code);
            check("dir_at_pulse", dir_out, e.dir);
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish within cycle budget");
      $fatal(1);
   end

   initial begin
      int waited;
      reset   = 1'b1;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      m_ext = 1'b0; m_brk = 1'b0; m_dir = 4'b0000;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_dir", dir_out, 4'b0000);
      check("rst_scan_code", scan_code, 8'h00);
      check("rst_scan_valid", scan_valid, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);

      send(8'hE0); send(8'h75);
      check("arrow_up", dir_out, 4'b0001);

      send(8'hE0); send(8'h6B);
      check("arrow_left", dir_out, 4'b0100);
      send(8'hE0); send(8'hF0); send(8'h74);
      check("mismatched_break", dir_out, 4'b0100);
      send(8'hE0); send(8'hF0); send(8'h6B);
      check("matched_break", dir_out, 4'b0000);

      send(8'hE0); send(8'h72);
      check("arrow_down", dir_out, 4'b0010);
      send(8'hE0); send(8'h74);
      check("override_right", dir_out, 4'b1000);
      send(8'hE0); send(8'h74);
      check("typematic_repeat", dir_out, 4'b1000);

      ps2_frame(8'h75, 1'b1, 1'b0);
      check("bad_parity_dir", dir_out, 4'b1000);
      ps2_frame(8'h75, 1'b0, 1'b1);
      check("bad_stop_dir", dir_out, 4'b1000);
      send(8'hE0);
      ps2_frame(8'h6B, 1'b1, 1'b0);
      send(8'h75);
      check("ext_cleared_by_err", dir_out, 4'b1000);

      send(8'hE0); send(8'h6B);
      check("pre_reset_dir", dir_out, 4'b0100);
      for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_ext = 1'b0; m_brk = 1'b0; m_dir = 4'b0000;
      check("midframe_rst_dir", dir_out, 4'b0000);
      check("midframe_rst_code", scan_code, 8'h00);
      check("midframe_rst_pulses", {scan_valid, frame_err}, 2'b00);
      repeat (200) @(negedge clk);
      check("post_rst_dir", dir_out, 4'b0000);

      expect_frame(8'h00, 1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b0);
      waited = 0;
      while (!frame_err && waited < 50100) begin
         @(negedge clk);
         waited++;
      end
      check("timeout_seen", frame_err, 1'b1);
      check("timeout_latency_ok", (waited >= 49960 && waited <= 49990), 1'b1);
      repeat (20) @(negedge clk);
      send(8'hE0); send(8'h72);
      check("after_timeout_decode", dir_out, 4'b0010);
      send(8'hE0); send(8'hF0); send(8'h72);
      check("release_down", dir_out, 4'b0000);

      send(8'h1D);
`ifdef PS2_WASD_EN
      check("wasd_w_make", dir_out, 4'b0001);
`else
      check("wasd_w_make", dir_out, 4'b0000);
`endif
      send(8'hF0); send(8'h1D);
      check("wasd_w_break", dir_out, 4'b0000);

      repeat (50) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
